// File: rtl/pov_spi_tx_pkg.sv
// Shared types and helpers for the point-of-view SPI transmitter.
package pov_spi_tx_pkg;

    // Default component width; must track the receiver's fixed-point width.
    localparam int DEFAULT_FW = 24;

    // Vectors per frame: playerX/Y, facingX/Y, vplaneX/Y.
    localparam int VEC_COUNT = 6;

    // Transmitter states. Each state's line values are loaded on entry.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    // Total frame length in bits for a given component width.
    function automatic int frame_bits(input int fw);
        return VEC_COUNT * fw;
    endfunction

endpackage

// File: rtl/pov_spi_tx_phase.sv
// Down-counting phase timer: loads a length, counts to zero and holds there.
module spi_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc,
    output logic         o_pre_tc
);

    logic [W-1:0] r_count;

    // Reload on request, otherwise count down and park at zero (never wraps).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Terminal count marks the last cycle of a phase; pre-terminal the one before.
    assign o_tc     = (r_count == '0);
    assign o_pre_tc = (r_count == W'(1));

endmodule

// File: rtl/pov_spi_tx.sv
// SPI mode-0 master that sends one point-of-view vector set as a single
// ss_n-framed, MSB-first frame, paced by a CLK_DIV half-period.
module pov_spi_tx
    import pov_spi_tx_pkg::*;
#(
    parameter int FW      = DEFAULT_FW,
    parameter int CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [FW-1:0] i_playerX,
    input  logic [FW-1:0] i_playerY,
    input  logic [FW-1:0] i_facingX,
    input  logic [FW-1:0] i_facingY,
    input  logic [FW-1:0] i_vplaneX,
    input  logic [FW-1:0] i_vplaneY,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_sclk,
    output logic          o_mosi,
    output logic          o_ss_n
);

    localparam int FRAME_BITS = frame_bits(FW);
    localparam int PW         = $clog2(2 * CLK_DIV);
    localparam int BW         = $clog2(FRAME_BITS + 1);

    localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_GAP   = PW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_ALL = BW'(FRAME_BITS);

    // A one-cycle half period cannot give the receiver's synchronisers time.
    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("pov_spi_tx: CLK_DIV must be at least 2");
        end
    endgenerate

    spi_state_t               r_state;
    // The bit currently on the wire lives in r_mosi; r_shift holds the rest.
    logic [FRAME_BITS-2:0]    r_shift;
    logic [BW-1:0]            r_bits;
    logic                     r_ss_n;
    logic                     r_sclk;
    logic                     r_mosi;
    logic                     r_busy;
    logic                     r_done;

    logic [FRAME_BITS-1:0]    w_frame;
    logic                     w_tc;
    logic                     w_pre_tc;
    logic                     w_load;
    logic [PW-1:0]            w_load_val;

    assign w_frame = {i_playerX, i_playerY, i_facingX, i_facingY, i_vplaneX, i_vplaneY};

    spi_phase_timer #(
        .W (PW)
    ) u_phase (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc),
        .o_pre_tc   (w_pre_tc)
    );

    // Reload the phase timer on every state entry; only GAP lasts two half periods.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = PH_HALF;
        if (r_state == ST_IDLE) begin
            w_load = i_start;
        end else begin
            w_load = w_tc;
        end
        if (r_state == ST_HOLD) begin
            w_load_val = PH_GAP;
        end
    end

    // Frame sequencer: every output is registered and set on state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bits  <= '0;
            r_ss_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state <= ST_LOW;
                        r_shift <= w_frame[FRAME_BITS-2:0];
                        r_mosi  <= w_frame[FRAME_BITS-1];
                        r_bits  <= BITS_ALL;
                        r_ss_n  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (w_tc) begin
                        r_state <= ST_HIGH;
                        r_sclk  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_tc) begin
                        r_sclk  <= 1'b0;
                        r_bits  <= r_bits - 1'b1;
                        r_shift <= {r_shift[FRAME_BITS-3:0], 1'b0};
                        if (r_bits > BW'(1)) begin
                            r_state <= ST_LOW;
                            r_mosi  <= r_shift[FRAME_BITS-2];
                        end else begin
                            r_state <= ST_HOLD;
                            r_mosi  <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tc) begin
                        r_state <= ST_GAP;
                        r_ss_n  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_tc) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (w_pre_tc) begin
                        // Registered one cycle ahead so done lands on GAP's final cycle.
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ss_n  <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_mosi  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_ss_n = r_ss_n;

endmodule
